// File: rtl/mem_port_if.sv
// Downstream memory/IO port: a single outstanding request, held until a one-cycle m_ack.
interface mem_port_if #(
  parameter int RV = 32,
  parameter int VA = RV
);
  logic                 m_req;
  logic                 m_we;
  logic                 m_io;
  logic [VA-1:RV/16]    m_addr;
  logic [RV/8-1:0]      m_wmask;
  logic [RV-1:0]        m_wdata;
  logic                 m_ack;
  logic [RV-1:0]        m_rdata;

  modport master (
    output m_req, m_we, m_io, m_addr, m_wmask, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_io, m_addr, m_wmask, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch, data read and data write (write > read > fetch); one request in flight.
// Request->m_req 1 cycle, m_ack->done pulse 1 cycle; holds m_* until m_ack. MEM_TIMEOUT_EN adds a TMO-cycle abort with bus_err.
module mem_port_arbiter #(
  parameter int RV  = 32,
  parameter int VA  = RV,
  parameter int TMO = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifetch,
  input  logic [VA-1:1]       pc,
  input  logic [1:0]          rstrobe,
  input  logic [RV/8-1:0]     wmask,
  input  logic [VA-1:RV/16]   addr,
  input  logic [RV-1:0]       wdata,
  input  logic                io_access,
  output logic                idone,
  output logic                rdone,
  output logic                wdone,
  output logic [RV-1:0]       rdata,
  output logic [15:0]         idata,
  output logic                bus_err,
  mem_port_if.master          m
);

  typedef enum logic [2:0] {IDLE, FETCH, READ, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  state_t              kind_q;
  logic [VA-1:RV/16]   addr_q;
  logic [RV-1:0]       wdata_q;
  logic [RV-1:0]       rdat_q;
  logic [RV/8-1:0]     wmask_q;
  logic [1:0]          rstrobe_q;
  logic                io_q;
  logic                pc1_q;
  logic                err_q;
  logic                busy;
  logic                timeout;

  assign busy = (state_q == FETCH) || (state_q == READ) || (state_q == WRITE);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q;

  // Counter is held at zero while idle, so it starts clean on every new request.
  always_ff @(posedge clk) begin
    if (reset)                 cnt_q <= '0;
    else if (!busy)            cnt_q <= '0;
    else if (!m.m_ack)         cnt_q <= cnt_q + 8'd1;
  end

  assign timeout = busy && !m.m_ack && (cnt_q == 8'(TMO - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|wmask)        state_d = WRITE;
        else if (|rstrobe) state_d = READ;
        else if (ifetch)   state_d = FETCH;
      end
      FETCH, READ, WRITE: begin
        if (m.m_ack || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q    <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdat_q    <= '0;
      wmask_q   <= '0;
      rstrobe_q <= '0;
      io_q      <= 1'b0;
      pc1_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d != IDLE) begin
        kind_q    <= state_d;
        err_q     <= 1'b0;
        rstrobe_q <= rstrobe;
        pc1_q     <= pc[1];
        wdata_q   <= wdata;
        if (state_d == FETCH) begin
          addr_q  <= pc[VA-1:RV/16];
          io_q    <= 1'b0;
          wmask_q <= '0;
        end else begin
          addr_q  <= addr;
          io_q    <= io_access;
          wmask_q <= wmask;
        end
      end
      // An ack in the timeout cycle takes precedence and completes normally.
      if (busy && m.m_ack) begin
        rdat_q <= m.m_rdata;
      end else if (timeout) begin
        rdat_q <= '1;
        err_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    m.m_req   = busy;
    m.m_we    = (state_q == WRITE);
    m.m_io    = io_q;
    m.m_addr  = addr_q;
    m.m_wmask = (state_q == WRITE) ? wmask_q : '0;
    m.m_wdata = wdata_q;
    idone     = (state_q == DONE) && (kind_q == FETCH);
    rdone     = (state_q == DONE) && (kind_q == READ);
    wdone     = (state_q == DONE) && (kind_q == WRITE);
    bus_err   = (state_q == DONE) && err_q;
    rdata     = rdat_q;
    // High-byte-only read is returned right-justified; an aborted read stays all ones.
    if (rstrobe_q == 2'b10 && !err_q) rdata = {{(RV-8){1'b0}}, rdat_q[15:8]};
  end

  generate
    if (RV == 32) begin : g_idata32
      assign idata = pc1_q ? rdat_q[31:16] : rdat_q[15:0];
    end else begin : g_idata16
      assign idata = rdat_q[15:0];
    end
  endgenerate

endmodule
